// File: rtl/sine_pwm_gen.sv
// Sine-modulated PWM generator.
// An 8-bit free-running counter defines a 256-cycle PWM period. At the last
// cycle of each period a 16-bit phase accumulator advances and the next duty
// value is computed from a quarter-wave sine table scaled by 'amp'.
module sine_pwm_gen (
    input  logic        clk1,
    input  logic        rst,
    input  logic        enable,
    input  logic [15:0] freq_word,
    input  logic        freq_load,
    input  logic [7:0]  amp,
    output logic        pwm_out,
    output logic [7:0]  duty,
    output logic        sample_strobe
);

    logic [7:0]         cnt;
    logic [15:0]        phase;
    logic [15:0]        freq_shadow;
    logic [15:0]        freq_active;
    logic [7:0]         duty_reg;

    logic               boundary;
    logic [1:0]         quad;
    logic [5:0]         qidx;
    logic [6:0]         tab_addr;
    logic [6:0]         tab_mag;
    logic signed [7:0]  sin_val;
    logic signed [8:0]  amp_s;
    logic signed [16:0] prod;
    logic signed [16:0] scaled;
    logic [7:0]         duty_next;

    // Last cycle of a running period; reset suppresses it outright.
    assign boundary      = enable & (cnt == 8'hFF) & ~rst;
    assign sample_strobe = boundary;
    assign duty          = duty_reg;

    // Fold the 8-bit phase index onto the first quadrant (0..64 inclusive).
    assign quad     = phase[15:14];
    assign qidx     = phase[13:8];
    assign tab_addr = quad[0] ? (7'd64 - {1'b0, qidx}) : {1'b0, qidx};

    // Quarter-wave table: round(127*sin(2*pi*k/256)), k = 0..64.
    always_comb begin
        tab_mag = 7'd0;
        case (tab_addr)
            7'd0:  tab_mag = 7'd0;
            7'd1:  tab_mag = 7'd3;
            7'd2:  tab_mag = 7'd6;
            7'd3:  tab_mag = 7'd9;
            7'd4:  tab_mag = 7'd12;
            7'd5:  tab_mag = 7'd16;
            7'd6:  tab_mag = 7'd19;
            7'd7:  tab_mag = 7'd22;
            7'd8:  tab_mag = 7'd25;
            7'd9:  tab_mag = 7'd28;
            7'd10: tab_mag = 7'd31;
            7'd11: tab_mag = 7'd34;
            7'd12: tab_mag = 7'd37;
            7'd13: tab_mag = 7'd40;
            7'd14: tab_mag = 7'd43;
            7'd15: tab_mag = 7'd46;
            7'd16: tab_mag = 7'd49;
            7'd17: tab_mag = 7'd51;
            7'd18: tab_mag = 7'd54;
            7'd19: tab_mag = 7'd57;
            7'd20: tab_mag = 7'd60;
            7'd21: tab_mag = 7'd63;
            7'd22: tab_mag = 7'd65;
            7'd23: tab_mag = 7'd68;
            7'd24: tab_mag = 7'd71;
            7'd25: tab_mag = 7'd73;
            7'd26: tab_mag = 7'd76;
            7'd27: tab_mag = 7'd78;
            7'd28: tab_mag = 7'd81;
            7'd29: tab_mag = 7'd83;
            7'd30: tab_mag = 7'd85;
            7'd31: tab_mag = 7'd88;
            7'd32: tab_mag = 7'd90;
            7'd33: tab_mag = 7'd92;
            7'd34: tab_mag = 7'd94;
            7'd35: tab_mag = 7'd96;
            7'd36: tab_mag = 7'd98;
            7'd37: tab_mag = 7'd100;
            7'd38: tab_mag = 7'd102;
            7'd39: tab_mag = 7'd104;
            7'd40: tab_mag = 7'd106;
            7'd41: tab_mag = 7'd107;
            7'd42: tab_mag = 7'd109;
            7'd43: tab_mag = 7'd111;
            7'd44: tab_mag = 7'd112;
            7'd45: tab_mag = 7'd113;
            7'd46: tab_mag = 7'd115;
            7'd47: tab_mag = 7'd116;
            7'd48: tab_mag = 7'd117;
            7'd49: tab_mag = 7'd118;
            7'd50: tab_mag = 7'd120;
            7'd51: tab_mag = 7'd121;
            7'd52: tab_mag = 7'd122;
            7'd53: tab_mag = 7'd122;
            7'd54: tab_mag = 7'd123;
            7'd55: tab_mag = 7'd124;
            7'd56: tab_mag = 7'd125;
            7'd57: tab_mag = 7'd125;
            7'd58: tab_mag = 7'd126;
            7'd59: tab_mag = 7'd126;
            7'd60: tab_mag = 7'd126;
            7'd61: tab_mag = 7'd127;
            7'd62: tab_mag = 7'd127;
            7'd63: tab_mag = 7'd127;
            7'd64: tab_mag = 7'd127;
            default: tab_mag = 7'd0;
        endcase
    end

    // Second half of the cycle is the negated first half.
    assign sin_val = quad[1] ? -$signed({1'b0, tab_mag}) : $signed({1'b0, tab_mag});

    // Signed scale by amp, floor via arithmetic shift, re-centre on 128.
    // Result lies in -127..126, so the low byte added to 128 gives 1..254.
    assign amp_s     = $signed({1'b0, amp});
    assign prod      = sin_val * amp_s;
    assign scaled    = prod >>> 8;
    assign duty_next = 8'd128 + scaled[7:0];

    // Period counter; idle holds it at zero so a restart begins a full period.
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst)          cnt <= 8'd0;
        else if (!enable) cnt <= 8'd0;
        else              cnt <= cnt + 8'd1;
    end

    // Phase advances only on a completed period, using the outgoing increment.
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst)           phase <= 16'd0;
        else if (boundary) phase <= phase + freq_active;
    end

    // Shadow captures any load strobe regardless of run state.
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst)            freq_shadow <= 16'd0;
        else if (freq_load) freq_shadow <= freq_word;
    end

    // Active increment swaps in at the boundary; a same-cycle load wins.
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst)           freq_active <= 16'd0;
        else if (boundary) freq_active <= freq_load ? freq_word : freq_shadow;
    end

    // Duty only changes at a boundary so each period is glitch-free.
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst)           duty_reg <= 8'd128;
        else if (!enable)  duty_reg <= 8'd128;
        else if (boundary) duty_reg <= duty_next;
    end

    // Registered compare; output lags the counter by one cycle.
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) pwm_out <= 1'b0;
        else     pwm_out <= enable & (cnt < duty_reg);
    end

endmodule

// File: doc/sine_pwm_gen.md
SINE_PWM_GEN -- requirements
Module: sine_pwm_gen

Interface
REQ-001 Parameters: none; PWM resolution fixed at 8 bits, phase accumulator fixed at 16 bits.
REQ-002 clk1  input  1  single system clock; all state on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 enable  input  1  run control; 0 = output idle, phase held.
REQ-005 freq_word  input  16  phase increment per PWM period, unsigned.
REQ-006 freq_load  input  1  one-cycle strobe capturing freq_word into the shadow register.
REQ-007 amp  input  8  unsigned amplitude scale; 255 = full scale.
REQ-008 pwm_out  output  1  registered PWM waveform.
REQ-009 duty  output  8  currently active duty value (duty_reg).
REQ-010 sample_strobe  output  1  one-cycle pulse on the last cycle of each PWM period.

Function
REQ-011 Internal state: cnt[7:0], phase[15:0], freq_shadow[15:0], freq_active[15:0], duty_reg[7:0], pwm_out flop.
REQ-012 enable=1: cnt increments by 1 each cycle and wraps 255->0; one PWM period = 256 cycles.
REQ-013 enable=0: cnt <= 0, duty_reg <= 128, phase and freq_active held, pwm_out <= 0, sample_strobe = 0.
REQ-014 pwm_out <= enable & (cnt < duty_reg); pwm_out lags cnt by one cycle and is high for exactly duty_reg cycles per full period.
REQ-015 Period boundary = cycle with enable=1 and cnt=255; sample_strobe = 1 combinationally in exactly that cycle.
REQ-016 At boundary: phase <= phase + freq_active (mod 2^16, wrap silent).
REQ-017 At boundary: duty_reg <= 128 + ((s(phase[15:8]) * amp) >>> 8), using pre-increment phase; signed multiply, arithmetic shift (floor).
REQ-018 s(i) = round(127*sin(2*pi*i/256)), i = 0..255, signed 8-bit; quarter-wave folding or full table allowed, values must match bit-exactly.
REQ-019 Key values: s(0)=0, s(64)=127, s(128)=0, s(192)=-127; duty range 1..254 for every amp.
REQ-020 amp sampled combinationally in the boundary cycle only; changes elsewhere have no effect.
REQ-021 freq_load=1 in any cycle: freq_shadow <= freq_word.
REQ-022 At boundary: freq_active <= freq_load ? freq_word : freq_shadow; increment applied in that same boundary uses the old freq_active.
REQ-023 New duty_reg takes effect starting with cnt=0 of the following period; no mid-period duty change.
REQ-024 enable falling mid-period: period aborted, no phase update; enable rising restarts at cnt=0 with duty_reg=128.

Reset
REQ-025 rst=1 forces immediately: cnt=0, phase=0, freq_shadow=0, freq_active=0, duty_reg=128, pwm_out=0; sample_strobe=0 while rst=1.
REQ-026 Reset mid-period discards partial period; after release with enable=1, first cycle has cnt=0.

Verification
REQ-027 Reset then enable=1, freq=0, amp=255 -> duty=128 every period, pwm_out high exactly 128 of 256 cycles, sample_strobe every 256 cycles.
REQ-028 freq_load with 0x4000, amp=255, from reset -> freq_active live after period 1; duty per period 128,128,128,254,128,1,128,254...
REQ-029 amp=0 with freq=0x4000 -> duty stays 128 for all periods.
REQ-030 freq_load 0x2000 at cnt=100, then 0x4000 at cnt=255 same period -> freq_active=0x4000 from next boundary, 0x2000 never applied.
REQ-031 enable dropped at cnt=50 -> next cycle cnt=0, pwm_out=0, phase unchanged; re-enable -> period restarts, duty=128.
REQ-032 rst pulsed at cnt=200 with phase=0x8000 -> all state at reset values asynchronously, pwm_out=0 before next clock edge.
